// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bus into the data-memory arbiter: one instance per requester.
// The requester (master) drives the request fields; the arbiter (slave) returns
// the grant and the one-cycle-later read response.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-port RAM between the CPU
// load/store unit and the AXI debug/load path. The CPU wins while running,
// bounded by a starvation counter; the AXI side wins while the CPU is halted.
// Read data comes back exactly one cycle after the grant and is steered to the
// requester that issued the read.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESET,
    input  logic                 cpu_halted,
    dmem_port_arbiter_if.slave   cpu,
    dmem_port_arbiter_if.slave   axi,
    output logic                 mem_en,
    output logic [3:0]           mem_wstrb,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic [3:0]           axi_wait_cnt
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rd_pend_q,  rd_pend_d;
    logic       rd_owner_q, rd_owner_d;   // 0 = CPU, 1 = AXI

    logic cpu_gnt;
    logic axi_gnt;
    logic cpu_rvalid;
    logic axi_rvalid;

    // Grant decode, memory port mux and next-state for counter and read tag.
    always_comb begin
        cpu_gnt    = 1'b0;
        axi_gnt    = 1'b0;
        mem_en     = 1'b0;
        mem_wstrb  = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        wait_cnt_d = wait_cnt_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = 1'b0;

        if (!S_AXI_ARESET) begin
            if (cpu_halted) begin
                axi_gnt = axi.req;
                cpu_gnt = cpu.req & ~axi.req;
            end else if (axi.req && (!cpu.req || wait_cnt_q == WAIT_LIMIT)) begin
                axi_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu.req;
            end
        end

        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
            mem_wstrb = cpu.we ? cpu.wstrb : 4'b0000;
        end else if (axi_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = axi.addr;
            mem_wdata = axi.wdata;
            mem_wstrb = axi.we ? axi.wstrb : 4'b0000;
        end

        // Starvation count: any cycle the AXI side asks and is refused.
        if (axi_gnt || !axi.req) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_pend_d  = (cpu_gnt & ~cpu.we) | (axi_gnt & ~axi.we);
        rd_owner_d = axi_gnt;
    end

    // State register; reset clears the counter and drops any pending read.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wait_cnt_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read response steering; reset also masks a response already in flight.
    always_comb begin
        cpu_rvalid = ~S_AXI_ARESET & rd_pend_q & ~rd_owner_q;
        axi_rvalid = ~S_AXI_ARESET & rd_pend_q &  rd_owner_q;
    end

    assign cpu.gnt      = cpu_gnt;
    assign axi.gnt      = axi_gnt;
    assign cpu.rvalid   = cpu_rvalid;
    assign axi.rvalid   = axi_rvalid;
    assign cpu.rdata    = cpu_rvalid ? mem_rdata : 32'h0;
    assign axi.rdata    = axi_rvalid ? mem_rdata : 32'h0;
    assign axi_wait_cnt = wait_cnt_q;

endmodule
